// File: rtl/mc_fuse_loader.sv
// Serial fuse loader for a macrocell array: a bit stream fills a shadow register,
// which is committed to the active register only after a complete stream.
module mc_fuse_loader #(
  parameter int NUM_MC = 16
) (
  input  logic                         clk_v,
  input  logic                         rst_n_v,
  input  logic                         load_start_v,
  input  logic                         bit_valid_v,
  input  logic                         bit_v,
  output logic                         bit_ready_v,
  input  logic                         rb_start_v,
  output logic                         rb_valid_v,
  output logic                         rb_bit_v,
  output logic                         rb_last_v,
  input  logic                         rb_ready_v,
  output logic                         busy_v,
  output logic                         done_v,
  output logic                         err_v,
  output logic [NUM_MC*21-1:0]         cfg_mux_v
);

  localparam int MC_BITS = 21;
  localparam int TOTAL   = NUM_MC * MC_BITS;
  localparam int CNT_W   = $clog2(TOTAL + 1);
  localparam int IDX_W   = $clog2(TOTAL);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    RB     = 2'd3
  } state_t;

  state_t             state;
  logic [TOTAL-1:0]   shadow;
  logic [TOTAL-1:0]   active;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   rb_idx;
  logic               done_q;
  logic               err_q;

  assign bit_ready_v = (state == LOAD);
  assign rb_valid_v  = (state == RB);
  assign rb_bit_v    = (state == RB) && active[rb_idx];
  assign rb_last_v   = (state == RB) && (rb_idx == IDX_LAST);
  assign busy_v      = (state != IDLE);
  assign done_v      = done_q;
  assign err_v       = err_q;
  assign cfg_mux_v   = active;

  always_ff @(posedge clk_v or negedge rst_n_v) begin
    if (!rst_n_v) begin
      state  <= IDLE;
      shadow <= '0;
      active <= '0;
      cnt    <= '0;
      rb_idx <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bit_valid_v)
            err_q <= 1'b1;
          // A load request wins over a simultaneous readback request, and clears err.
          if (load_start_v) begin
            state <= LOAD;
            cnt   <= '0;
            err_q <= 1'b0;
          end else if (rb_start_v) begin
            state  <= RB;
            rb_idx <= '0;
          end
        end
        LOAD: begin
          if (rb_start_v)
            err_q <= 1'b1;
          if (load_start_v) begin
            cnt <= '0;
          end else if (bit_valid_v) begin
            shadow[cnt] <= bit_v;
            cnt         <= cnt + 1'b1;
            if (cnt == CNT_LAST)
              state <= COMMIT;
          end
        end
        COMMIT: begin
          if (bit_valid_v)
            err_q <= 1'b1;
          active <= shadow;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        RB: begin
          if (load_start_v || bit_valid_v)
            err_q <= 1'b1;
          if (rb_ready_v) begin
            rb_idx <= rb_idx + 1'b1;
            if (rb_idx == IDX_LAST)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_fuse_loader.sv
// Directed bench for mc_fuse_loader with two macrocells (42-bit stream).
module tb_mc_fuse_loader;

  localparam int NUM_MC = 2;
  localparam int TOTAL  = NUM_MC * 21;

  logic             clk_v = 1'b0;
  logic             rst_n_v = 1'b0;
  logic             load_start_v = 1'b0;
  logic             bit_valid_v = 1'b0;
  logic             bit_v = 1'b0;
  logic             bit_ready_v;
  logic             rb_start_v = 1'b0;
  logic             rb_valid_v;
  logic             rb_bit_v;
  logic             rb_last_v;
  logic             rb_ready_v = 1'b0;
  logic             busy_v;
  logic             done_v;
  logic             err_v;
  logic [TOTAL-1:0] cfg_mux_v;

  int nvec = 0;
  int nmis = 0;
  int done_cnt = 0;

  mc_fuse_loader #(.NUM_MC(NUM_MC)) dut (
    .clk_v        (clk_v),
    .rst_n_v      (rst_n_v),
    .load_start_v (load_start_v),
    .bit_valid_v  (bit_valid_v),
    .bit_v        (bit_v),
    .bit_ready_v  (bit_ready_v),
    .rb_start_v   (rb_start_v),
    .rb_valid_v   (rb_valid_v),
    .rb_bit_v     (rb_bit_v),
    .rb_last_v    (rb_last_v),
    .rb_ready_v   (rb_ready_v),
    .busy_v       (busy_v),
    .done_v       (done_v),
    .err_v        (err_v),
    .cfg_mux_v    (cfg_mux_v)
  );

  always #5 clk_v = ~clk_v;

  always @(negedge clk_v) if (done_v) done_cnt++;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_load();
    @(negedge clk_v);
    load_start_v = 1'b1;
    @(negedge clk_v);
    load_start_v = 1'b0;
  endtask

  // Drives n bits from pat; rb_start_v is pulsed alongside bit rb_at (use -1 for none).
  task automatic stream(input logic [TOTAL-1:0] pat, input int n, input int rb_at);
    int rdy = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk_v);
      rdy += int'(bit_ready_v);
      bit_valid_v = 1'b1;
      bit_v       = pat[i];
      rb_start_v  = (i == rb_at);
    end
    chk("ready_count", 64'(rdy), 64'(n));
  endtask

  // Call right after stream() of the final bit; checks the one-cycle commit timing.
  task automatic finish_commit(input logic [TOTAL-1:0] pat, input logic hold_valid);
    int d0;
    @(negedge clk_v);
    bit_valid_v = hold_valid;
    bit_v       = 1'b0;
    rb_start_v  = 1'b0;
    d0 = done_cnt;
    chk("commit_ready", 64'(bit_ready_v), 64'd0);
    chk("commit_busy", 64'(busy_v), 64'd1);
    chk("commit_done", 64'(done_v), 64'd0);
    @(negedge clk_v);
    bit_valid_v = 1'b0;
    chk("done_pulse", 64'(done_v), 64'd1);
    chk("cfg_after_commit", 64'(cfg_mux_v), 64'(pat));
    chk("busy_after_commit", 64'(busy_v), 64'd0);
    @(negedge clk_v);
    chk("done_one_cycle", 64'(done_v), 64'd0);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk_v);
    rst_n_v = 1'b0;
    @(negedge clk_v);
    rst_n_v = 1'b1;
  endtask

  initial begin
    logic [TOTAL-1:0] p_alt;
    logic [TOTAL-1:0] p_one;
    logic [TOTAL-1:0] p_oe;
    logic [TOTAL-1:0] p_mix;
    int idx;
    int cyc;
    int d0;
    p_alt = 42'h2AA_AAAA_AAAA;
    p_one = '1;
    p_oe  = 42'h0;
    p_oe[37] = 1'b1;
    p_mix = 42'h155_5555_5555;

    // Reset state
    repeat (2) @(negedge clk_v);
    chk("rst_cfg", 64'(cfg_mux_v), 64'd0);
    chk("rst_busy", 64'(busy_v), 64'd0);
    chk("rst_done", 64'(done_v), 64'd0);
    chk("rst_err", 64'(err_v), 64'd0);
    chk("rst_ready", 64'(bit_ready_v), 64'd0);
    chk("rst_rbvalid", 64'(rb_valid_v), 64'd0);
    rst_n_v = 1'b1;

    // Test 1: alternating stream
    start_load();
    stream(p_alt, TOTAL, -1);
    finish_commit(p_alt, 1'b0);
    chk("t1_err", 64'(err_v), 64'd0);

    // Test 2: restart mid-load
    d0 = done_cnt;
    start_load();
    stream(p_mix, 20, -1);
    @(negedge clk_v);
    bit_valid_v  = 1'b0;
    load_start_v = 1'b1;
    @(negedge clk_v);
    load_start_v = 1'b0;
    chk("t2_cfg_unchanged", 64'(cfg_mux_v), 64'(p_alt));
    stream(p_one, TOTAL, -1);
    finish_commit(p_one, 1'b0);
    chk("t2_single_done", 64'(done_cnt - d0), 64'd1);
    chk("t2_err", 64'(err_v), 64'd0);

    // Test 3: readback with rb_ready_v toggling
    start_load();
    stream(p_alt, TOTAL, -1);
    finish_commit(p_alt, 1'b0);
    @(negedge clk_v);
    rb_start_v = 1'b1;
    @(negedge clk_v);
    rb_start_v = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < TOTAL && cyc < 200) begin
      rb_ready_v = cyc[0];
      chk("rb_valid", 64'(rb_valid_v), 64'd1);
      chk("rb_bit", 64'(rb_bit_v), 64'(p_alt[idx]));
      chk("rb_last", 64'(rb_last_v), 64'(idx == TOTAL - 1));
      if (rb_ready_v) idx++;
      cyc++;
      @(negedge clk_v);
    end
    rb_ready_v = 1'b0;
    chk("rb_all_bits", 64'(idx), 64'(TOTAL));
    chk("rb_busy_end", 64'(busy_v), 64'd0);
    chk("rb_valid_end", 64'(rb_valid_v), 64'd0);
    chk("rb_err", 64'(err_v), 64'd0);

    // Test 4: reset mid-load
    d0 = done_cnt;
    start_load();
    stream(p_one, 30, -1);
    @(negedge clk_v);
    bit_valid_v = 1'b0;
    rst_n_v = 1'b0;
    #1;
    chk("t4_cfg", 64'(cfg_mux_v), 64'd0);
    chk("t4_busy", 64'(busy_v), 64'd0);
    @(negedge clk_v);
    rst_n_v = 1'b1;
    repeat (3) @(negedge clk_v);
    chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t4_cfg_hold", 64'(cfg_mux_v), 64'd0);
    start_load();
    stream(p_mix, TOTAL, -1);
    finish_commit(p_mix, 1'b0);

    // Test 5: protocol errors
    @(negedge clk_v);
    bit_valid_v = 1'b1;
    @(negedge clk_v);
    bit_valid_v = 1'b0;
    chk("t5_err_idle", 64'(err_v), 64'd1);
    repeat (2) @(negedge clk_v);
    chk("t5_err_sticky", 64'(err_v), 64'd1);
    start_load();
    chk("t5_err_cleared", 64'(err_v), 64'd0);
    stream(p_alt, 12, 10);
    chk("t5_err_rb_in_load", 64'(err_v), 64'd1);
    start_load();
    stream(p_alt, TOTAL, 10);
    finish_commit(p_alt, 1'b0);
    chk("t5_err_after_load", 64'(err_v), 64'd1);
    start_load();
    chk("t5_err_cleared2", 64'(err_v), 64'd0);
    stream(p_one, TOTAL, -1);
    finish_commit(p_one, 1'b1);
    chk("t5_err_commit", 64'(err_v), 64'd1);

    // Test 6: field mapping, macrocell 1 oe[0]
    do_reset();
    start_load();
    stream(p_oe, TOTAL, -1);
    finish_commit(p_oe, 1'b0);
    chk("t6_mc1", 64'(cfg_mux_v[41:21]), 64'h10000);
    chk("t6_mc0", 64'(cfg_mux_v[20:0]), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mc_fuse_loader.md
Name: mc_fuse_loader

Overview:
- Serial configuration loader for an array of macrocells: accepts a fuse bitstream over a valid/ready bit interface and drives every per-macrocell mux select (pt1_mux … o_mux, oe_mux, gclk_mux) from a committed register.
- Double-buffered: a load fills a shadow register; the active register that drives the macrocells changes only when a complete stream has arrived.
- Also serialises the active register back out for readback, in the same bit order.

Parameters:
- NUM_MC, 16, number of macrocells configured.
- MC_BITS, 21 (fixed, not overridable), config bits per macrocell.
- TOTAL, NUM_MC*MC_BITS (derived), stream length in bits.

Ports:
- clk_v  input  1  clock, rising edge.
- rst_n_v  input  1  asynchronous, active-low reset.
- load_start_v  input  1  pulse: begin a new load.
- bit_valid_v  input  1  incoming fuse bit valid.
- bit_v  input  1  incoming fuse bit.
- bit_ready_v  output  1  loader accepts a bit this cycle.
- rb_start_v  input  1  pulse: begin readback.
- rb_valid_v  output  1  readback bit valid.
- rb_bit_v  output  1  readback bit.
- rb_last_v  output  1  current readback bit is index TOTAL-1.
- rb_ready_v  input  1  consumer accepts readback bit.
- busy_v  output  1  state != IDLE.
- done_v  output  1  one-cycle pulse: active register updated.
- err_v  output  1  sticky protocol error.
- cfg_mux_v  output  TOTAL  active config; macrocell m owns bits [m*21 +: 21].

Behaviour:
- Field order within a macrocell, index 0..20: pt1, pt2, pt3, pt4, pt5, gclr, pt4_func, pt5_func, xor_a, xor_b, xor_inv, d, dfast, storage, fb, o (0..15), then oe[0..2] (16..18), then gclk[0..1] (19..20).
- Stream order: the k-th accepted bit (k from 0) is written to shadow[k]. Bit k belongs to macrocell k/21, field k%21.
- Reset: state IDLE; shadow, active, bit counter and rb index all 0; all outputs 0. cfg_mux_v = 0 selects the default path on every mux.
- Reset mid-load or mid-readback aborts immediately. Partial shadow contents are discarded; active is cleared.
- States: IDLE, LOAD, COMMIT, RB.
- IDLE:
  - load_start_v → LOAD; counter := 0; err_v := 0.
  - rb_start_v alone → RB; index := 0.
  - load_start_v and rb_start_v together → LOAD; readback is dropped with no error.
  - bit_valid_v high in IDLE → err_v := 1; the bit is dropped.
- LOAD:
  - bit_ready_v = 1.
  - On bit_valid_v & bit_ready_v: shadow[counter] := bit_v; counter := counter+1.
  - When the accepted bit has counter == TOTAL-1 → COMMIT.
  - load_start_v in LOAD restarts: counter := 0, no error. Shadow bits are overwritten as the new stream arrives.
  - rb_start_v in LOAD → err_v := 1; readback is ignored.
- COMMIT (exactly 1 cycle):
  - bit_ready_v = 0. Any bit_valid_v high here sets err_v := 1.
  - At the end of the cycle: active := shadow, done_v asserted for the following cycle, → IDLE.
  - Latency: last bit accepted at edge k → cfg_mux_v valid after edge k+1 → done_v high between edges k+1 and k+2.
- RB:
  - rb_valid_v = 1; rb_bit_v = active[index]; rb_last_v = (index == TOTAL-1).
  - Output holds stable while rb_ready_v is low.
  - On a handshake: index := index+1. After the handshake with rb_last_v high → IDLE.
  - load_start_v or bit_valid_v in RB → err_v := 1; readback continues.
- Active register is never modified except in COMMIT. Macrocells never see a partial configuration.
- err_v is sticky; it is cleared only by reset or by load_start_v accepted in IDLE.
- Counter width: clog2(TOTAL+1). No wrap occurs, since LOAD exits at TOTAL.

Test Plan:
1. NUM_MC=2 (TOTAL=42); reset, then load the stream bit k = k%2 with continuous valid → bit_ready_v high for 42 cycles. done_v pulses 2 edges after the last bit. cfg_mux_v = 42'h2AAAAAAAAAA (odd bits set). err_v = 0.
2. Load 20 bits, then pulse load_start_v, then load 42 bits of all 1s → a single done_v pulse; cfg_mux_v = all 1s; err_v = 0.
3. Commit the pattern from test 1, then rb_start_v with rb_ready_v toggling every other cycle → 42 bits read equal to cfg_mux_v in index order. rb_last_v is high only on bit 41. busy_v drops after the final handshake.
4. Assert rst_n_v low after 30 bits of a load → cfg_mux_v = 0, busy_v = 0, done_v never pulses. A subsequent full load works normally.
5. bit_valid_v high in IDLE, rb_start_v during LOAD, bit_valid_v during COMMIT → err_v is set at each. It stays set until the next load_start_v from IDLE. The load in progress still completes correctly.
6. Field mapping: stream with only bit 21+16 set → macrocell 1 oe_mux[0] = 1; all other fields of both macrocells = 0.
